alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 142 ++++++++++++++
 tb/tb_alu_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequencer that drives an external 8-bit ALU.
// It accepts one command, holds the ALU operands and mode pins for SETTLE
// cycles, captures the result with flags into the accumulator, and holds
// the response until it is consumed.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_opcode, cmd_mode  ALU function select and mode (logic/arith, low/high)
//   cmd_use_acc           operand A source: 1 = accumulator, 0 = cmd_a
//   cmd_a, cmd_b          command operands
//   alu_A, alu_B          registered operands driven to the ALU
//   alu_opcode            registered opcode driven to the ALU
//   alu_m/cn/l/h          registered ALU mode pins
//   alu_R                 ALU result
//   rsp_valid/rsp_ready   response handshake
//   rsp_result, rsp_flags captured result and {Z, N, P, EQ}
//   acc                   accumulator
//   busy                  high whenever not idle
module alu_seq #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_opcode,
    input  logic [1:0] cmd_mode,
    input  logic       cmd_use_acc,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [7:0] alu_A,
    output logic [7:0] alu_B,
    output logic [3:0] alu_opcode,
    output logic       alu_m,
    output logic       alu_cn,
    output logic       alu_l,
    output logic       alu_h,
    input  logic [7:0] alu_R,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic [3:0] rsp_flags,
    output logic [7:0] acc,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [7:0] alu_A_q;
    logic [7:0] alu_B_q;
    logic [3:0] alu_op_q;
    logic       alu_m_q;
    logic       alu_cn_q;
    logic       alu_l_q;
    logic       alu_h_q;
    logic [7:0] result_q;
    logic [3:0] flags_q;
    logic [7:0] acc_q;
    logic [3:0] flags_d;

    // Flags of the result being captured; EQ compares the held operands.
    always_comb begin
        flags_d = {(alu_R == 8'h00), alu_R[7], ^alu_R, (alu_A_q == alu_B_q)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            alu_A_q  <= '0;
            alu_B_q  <= '0;
            alu_op_q <= '0;
            alu_m_q  <= 1'b0;
            alu_cn_q <= 1'b0;
            alu_l_q  <= 1'b0;
            alu_h_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            acc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_A_q  <= cmd_use_acc ? acc_q : cmd_a;
                        alu_B_q  <= cmd_b;
                        alu_op_q <= cmd_opcode;
                        // mode[0] selects arithmetic, mode[1] selects the high half;
                        // carry-in is only asserted for arith-high.
                        alu_m_q  <= ~cmd_mode[0];
                        alu_cn_q <= &cmd_mode;
                        alu_l_q  <= ~cmd_mode[1];
                        alu_h_q  <= cmd_mode[1];
                        cnt_q    <= SETTLE_C;
                        state_q  <= DRIVE;
                    end
                end
                DRIVE: begin
                    // Counter value 1 marks the last settle cycle.
                    if (cnt_q <= 4'd1) begin
                        result_q <= alu_R;
                        acc_q    <= alu_R;
                        flags_q  <= flags_d;
                        cnt_q    <= '0;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign alu_A      = alu_A_q;
    assign alu_B      = alu_B_q;
    assign alu_opcode = alu_op_q;
    assign alu_m      = alu_m_q;
    assign alu_cn     = alu_cn_q;
    assign alu_l      = alu_l_q;
    assign alu_h      = alu_h_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign acc        = acc_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: two instances (SETTLE=1 and SETTLE=3)
// share clock and reset; a bench-side ALU supplies alu_R, and a
// transaction-level model predicts every output on every cycle.
module tb_alu_seq;

    logic       clk;
    logic       rst;
    logic       cmd_valid   [2];
    logic       cmd_ready   [2];
    logic [3:0] cmd_opcode  [2];
    logic [1:0] cmd_mode    [2];
    logic       cmd_use_acc [2];
    logic [7:0] cmd_a       [2];
    logic [7:0] cmd_b       [2];
    logic [7:0] alu_A       [2];
    logic [7:0] alu_B       [2];
    logic [3:0] alu_opcode  [2];
    logic       alu_m       [2];
    logic       alu_cn      [2];
    logic       alu_l       [2];
    logic       alu_h       [2];
    logic [7:0] alu_R       [2];
    logic       rsp_valid   [2];
    logic       rsp_ready   [2];
    logic [7:0] rsp_result  [2];
    logic [3:0] rsp_flags   [2];
    logic [7:0] acc         [2];
    logic       busy        [2];

    int vectors;
    int miscompares;

    // Stand-in ALU: 74181-flavoured, only needs to be deterministic.
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic m, input logic cn,
                                          input logic [7:0] a, input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] r;
        c = {7'b0, cn};
        if (m) begin
            case (op)
                4'b1100: r = a ^ b;
                4'b1011: r = a & b;
                4'b1110: r = a | b;
                default: r = ~(a ^ {op, op});
            endcase
        end else begin
            case (op)
                4'b1001: r = a + b + c;
                4'b1100: r = a + a + c;
                4'b0110: r = a - b - 8'd1 + c;
                default: r = a + {4'b0, op} + c;
            endcase
        end
        return r;
    endfunction

    function automatic int unsigned settle_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    alu_seq #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_opcode(cmd_opcode[0]), .cmd_mode(cmd_mode[0]), .cmd_use_acc(cmd_use_acc[0]),
        .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
        .alu_A(alu_A[0]), .alu_B(alu_B[0]), .alu_opcode(alu_opcode[0]),
        .alu_m(alu_m[0]), .alu_cn(alu_cn[0]), .alu_l(alu_l[0]), .alu_h(alu_h[0]),
        .alu_R(alu_R[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_result(rsp_result[0]), .rsp_flags(rsp_flags[0]),
        .acc(acc[0]), .busy(busy[0])
    );

    alu_seq #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_opcode(cmd_opcode[1]), .cmd_mode(cmd_mode[1]), .cmd_use_acc(cmd_use_acc[1]),
        .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
        .alu_A(alu_A[1]), .alu_B(alu_B[1]), .alu_opcode(alu_opcode[1]),
        .alu_m(alu_m[1]), .alu_cn(alu_cn[1]), .alu_l(alu_l[1]), .alu_h(alu_h[1]),
        .alu_R(alu_R[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_result(rsp_result[1]), .rsp_flags(rsp_flags[1]),
        .acc(acc[1]), .busy(busy[1])
    );

    assign alu_R[0] = alu_fn(alu_opcode[0], alu_m[0], alu_cn[0], alu_A[0], alu_B[0]);
    assign alu_R[1] = alu_fn(alu_opcode[1], alu_m[1], alu_cn[1], alu_A[1], alu_B[1]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input int k, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] at %0t: got %b expected %b", nm, k, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          chk_en;
    int unsigned cyc;
    bit          inflight [2];
    bit          showing  [2];
    int unsigned due      [2];
    logic [7:0]  e_A      [2];
    logic [7:0]  e_B      [2];
    logic [3:0]  e_op     [2];
    logic [3:0]  e_pins   [2];   // {m, cn, l, h}
    logic [7:0]  e_res    [2];
    logic [3:0]  e_flg    [2];
    logic [7:0]  e_acc    [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                inflight[k] = 0;
                showing[k]  = 0;
                e_A[k] = 8'h00; e_B[k] = 8'h00; e_op[k] = 4'h0; e_pins[k] = 4'h0;
                e_res[k] = 8'h00; e_flg[k] = 4'h0; e_acc[k] = 8'h00;
            end else if (showing[k]) begin
                if (rsp_ready[k]) showing[k] = 0;
            end else if (inflight[k]) begin
                if (cyc == due[k]) begin
                    logic [7:0] r;
                    r = alu_fn(e_op[k], e_pins[k][3], e_pins[k][2], e_A[k], e_B[k]);
                    e_res[k] = r;
                    e_acc[k] = r;
                    e_flg[k] = {(r == 8'h00), r[7], ^r, (e_A[k] == e_B[k])};
                    inflight[k] = 0;
                    showing[k]  = 1;
                end
            end else if (cmd_valid[k]) begin
                e_A[k]  = cmd_use_acc[k] ? e_acc[k] : cmd_a[k];
                e_B[k]  = cmd_b[k];
                e_op[k] = cmd_opcode[k];
                case (cmd_mode[k])
                    2'b00:   e_pins[k] = 4'b1010;
                    2'b01:   e_pins[k] = 4'b0010;
                    2'b10:   e_pins[k] = 4'b1001;
                    default: e_pins[k] = 4'b0101;
                endcase
                due[k]      = cyc + settle_of(k);
                inflight[k] = 1;
            end
        end
        if (rst) chk_en = 1;
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk1("cmd_ready", k, cmd_ready[k], !inflight[k] && !showing[k]);
                chk1("rsp_valid", k, rsp_valid[k], showing[k]);
                chk1("busy", k, busy[k], inflight[k] || showing[k]);
                chk8("acc", k, acc[k], e_acc[k]);
                chk8("rsp_result", k, rsp_result[k], e_res[k]);
                chk8("rsp_flags", k, {4'h0, rsp_flags[k]}, {4'h0, e_flg[k]});
                chk8("alu_A", k, alu_A[k], e_A[k]);
                chk8("alu_B", k, alu_B[k], e_B[k]);
                chk8("alu_opcode", k, {4'h0, alu_opcode[k]}, {4'h0, e_op[k]});
                chk8("alu_pins", k, {4'h0, alu_m[k], alu_cn[k], alu_l[k], alu_h[k]}, {4'h0, e_pins[k]});
                chk1("lh_exclusive", k, alu_l[k] & alu_h[k], 1'b0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input int k, input logic [3:0] op, input logic [1:0] mode,
                           input logic ua, input logic [7:0] a, input logic [7:0] b,
                           input int hold, output int lat);
        int n;
        n = 0;
        lat = 0;
        while (cmd_ready[k] !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) begin
            chk1("ready_timeout", k, cmd_ready[k], 1'b1);
            return;
        end
        cmd_opcode[k] = op; cmd_mode[k] = mode; cmd_use_acc[k] = ua;
        cmd_a[k] = a; cmd_b[k] = b; cmd_valid[k] = 1'b1;
        tick();
        cmd_valid[k] = 1'b0;
        // Scramble command inputs: latched values must not follow them.
        cmd_a[k] = 8'($urandom); cmd_b[k] = 8'($urandom);
        cmd_opcode[k] = 4'($urandom); cmd_mode[k] = 2'($urandom); cmd_use_acc[k] = 1'($urandom);
        lat = 1;
        while (rsp_valid[k] !== 1'b1 && lat < 40) begin tick(); lat++; end
        if (lat >= 40) begin
            chk1("rsp_timeout", k, rsp_valid[k], 1'b1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            cmd_valid[k] = 1'($urandom);
            cmd_a[k] = 8'($urandom);
            rsp_ready[k] = 1'b0;
            tick();
        end
        cmd_valid[k] = 1'b0;
        rsp_ready[k] = 1'b1;
        tick();
        rsp_ready[k] = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        vectors = 0;
        miscompares = 0;
        chk_en = 0;
        cyc = 0;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0; cmd_opcode[k] = 4'h0; cmd_mode[k] = 2'b00;
            cmd_use_acc[k] = 1'b0; cmd_a[k] = 8'h00; cmd_b[k] = 8'h00; rsp_ready[k] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        for (int k = 0; k < 2; k++) begin
            chk8("rst_acc", k, acc[k], 8'h00);
            chk1("rst_cmd_ready", k, cmd_ready[k], 1'b1);
            chk1("rst_rsp_valid", k, rsp_valid[k], 1'b0);
            chk1("rst_busy", k, busy[k], 1'b0);
            chk8("rst_alu_A", k, alu_A[k], 8'h00);
            chk8("rst_alu_B", k, alu_B[k], 8'h00);
            chk8("rst_alu_misc", k, {alu_opcode[k], alu_m[k], alu_cn[k], alu_l[k], alu_h[k]}, 8'h00);
        end

        // Zero and equal, logic-low
        run_cmd(0, 4'b1100, 2'b00, 1'b0, 8'h55, 8'h55, 1, lat);
        chk8("zeq_result", 0, rsp_result[0], 8'h00);
        chk8("zeq_flags", 0, {4'h0, rsp_flags[0]}, 8'h09);

        // Add, arith-low, SETTLE=1
        run_cmd(0, 4'b1001, 2'b01, 1'b0, 8'h3C, 8'h14, 0, lat);
        chk8("add_latency", 0, 8'(lat), 8'd2);
        chk8("add_pins", 0, {4'h0, alu_m[0], alu_cn[0], alu_l[0], alu_h[0]}, 8'h02);
        chk8("add_result", 0, rsp_result[0], 8'h50);
        chk8("add_flags", 0, {4'h0, rsp_flags[0]}, 8'h00);
        chk8("add_acc", 0, acc[0], 8'h50);

        // Accumulator chain
        run_cmd(0, 4'b1100, 2'b01, 1'b1, 8'hFF, 8'h33, 0, lat);
        chk8("chain_alu_A", 0, alu_A[0], 8'h50);
        chk8("chain_result", 0, rsp_result[0], 8'hA0);
        chk8("chain_flags", 0, {4'h0, rsp_flags[0]}, 8'h04);
        chk8("chain_acc", 0, acc[0], 8'hA0);

        // Backpressure and settle, arith-high, SETTLE=3
        run_cmd(1, 4'b1001, 2'b11, 1'b0, 8'h10, 8'h20, 5, lat);
        chk8("bp_latency", 1, 8'(lat), 8'd4);
        chk8("bp_pins", 1, {4'h0, alu_m[1], alu_cn[1], alu_l[1], alu_h[1]}, 8'h05);
        chk8("bp_result", 1, rsp_result[1], 8'h31);
        chk1("bp_idle_ready", 1, cmd_ready[1], 1'b1);
        chk1("bp_idle_busy", 1, busy[1], 1'b0);

        // Abort during the second DRIVE cycle
        cmd_opcode[1] = 4'b1001; cmd_mode[1] = 2'b01; cmd_use_acc[1] = 1'b0;
        cmd_a[1] = 8'h01; cmd_b[1] = 8'h02; cmd_valid[1] = 1'b1;
        tick();
        cmd_valid[1] = 1'b0;
        tick();
        chk1("abort_busy", 1, busy[1], 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk8("abort_acc", 1, acc[1], 8'h00);
        chk1("abort_ready", 1, cmd_ready[1], 1'b1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid[1] !== 1'b0) seen++;
            tick();
        end
        chk8("abort_no_rsp", 1, 8'(seen), 8'd0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            run_cmd(int'($urandom_range(1, 0)), 4'($urandom), 2'($urandom), 1'($urandom),
                    8'($urandom), 8'($urandom), int'($urandom_range(3, 0)), lat);
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
